// File: rtl/pmp_addr_bank.sv
// pmp_addr_bank
//   Bank of PMPNumRegions address registers with per-region sticky lock bits
//   and a sequenced clear. A clear walks the regions one per cycle. It reloads
//   ClearValue into every unlocked region and leaves locked regions untouched.
//   Lock bits are set only by writes and cleared only by reset.
//
//   State | Meaning
//   ------+-----------------------------------------------------------
//   IDLE  | accepting writes; clr_req_i starts a clear walk at region 0
//   CLEAR | one region per cycle is cleared (if unlocked); writes stall
//
// Ports
//   clk_i           clock
//   rst_ni          asynchronous active-low reset
//   wr_req_i        write request, held by the requester until accepted
//   wr_idx_i        write target region
//   wr_data_i       write data
//   wr_lock_i       lock the target region together with this write
//   wr_ready_o      write can be accepted this cycle (combinational)
//   wr_err_o        the write accepted this cycle is rejected (combinational)
//   clr_req_i       single-cycle pulse that starts the clear walk
//   busy_o          clear walk in progress
//   rd_idx_i        read region
//   rd_data_o       registered read data, 0 for an out-of-range index
//   csr_pmp_addr_o  all region addresses, straight from the registers
//   lock_o          per-region lock bits, straight from the registers

module pmp_addr_bank #(
  parameter int unsigned                PMPNumRegions = 4,
  parameter int unsigned                PMPAddrWidth  = 34,
  parameter logic [PMPAddrWidth-1:0]    ClearValue    = '1,
  localparam int unsigned               IdxW = (PMPNumRegions > 1) ? $clog2(PMPNumRegions) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,

  input  logic                     wr_req_i,
  input  logic [IdxW-1:0]          wr_idx_i,
  input  logic [PMPAddrWidth-1:0]  wr_data_i,
  input  logic                     wr_lock_i,
  output logic                     wr_ready_o,
  output logic                     wr_err_o,

  input  logic                     clr_req_i,
  output logic                     busy_o,

  input  logic [IdxW-1:0]          rd_idx_i,
  output logic [PMPAddrWidth-1:0]  rd_data_o,

  output logic [PMPAddrWidth-1:0]  csr_pmp_addr_o [PMPNumRegions],
  output logic [PMPNumRegions-1:0] lock_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e                     state_q, state_d;
  logic [IdxW-1:0]            cnt_q, cnt_d;
  logic [PMPAddrWidth-1:0]    region_q [PMPNumRegions];
  logic [PMPAddrWidth-1:0]    region_d [PMPNumRegions];
  logic [PMPNumRegions-1:0]   lock_q, lock_d;
  logic [PMPAddrWidth-1:0]    rd_data_q, rd_data_d;

  logic wr_idx_ok;
  logic wr_locked;
  logic wr_accept;
  logic wr_commit;
  logic rd_idx_ok;
  logic cnt_last;

  // Index ports are wider than needed when PMPNumRegions is not a power of
  // two, so both read and write indices are range-checked.
  assign wr_idx_ok = (32'(wr_idx_i) < PMPNumRegions);
  assign rd_idx_ok = (32'(rd_idx_i) < PMPNumRegions);

  // Never look at the lock vector with an out-of-range index.
  assign wr_locked = wr_idx_ok ? lock_q[wr_idx_i] : 1'b0;

  // A clear request wins over a write in the same cycle. The write stays
  // pending and is accepted once the walk has finished.
  assign wr_ready_o = (state_q == IDLE) && !clr_req_i;
  assign wr_accept  = wr_req_i && wr_ready_o;
  assign wr_err_o   = wr_accept && (!wr_idx_ok || wr_locked);
  assign wr_commit  = wr_accept && !wr_err_o;

  assign cnt_last = (32'(cnt_q) == (PMPNumRegions - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    region_d = region_q;
    lock_d   = lock_q;

    case (state_q)
      IDLE: begin
        if (clr_req_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        // clr_req_i is deliberately not looked at here.
        if (!lock_q[cnt_q]) begin
          region_d[cnt_q] = ClearValue;
        end
        if (cnt_last) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + IdxW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A write can only commit in IDLE, so it never competes with the walk.
    if (wr_commit) begin
      region_d[wr_idx_i] = wr_data_i;
      if (wr_lock_i) begin
        lock_d[wr_idx_i] = 1'b1;
      end
    end
  end

  // The read samples the registers as they were before this edge's update.
  always_comb begin
    rd_data_d = '0;
    if (rd_idx_ok) begin
      rd_data_d = region_q[rd_idx_i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lock_q    <= '0;
      rd_data_q <= '0;
      for (int unsigned i = 0; i < PMPNumRegions; i++) begin
        region_q[i] <= ClearValue;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lock_q    <= lock_d;
      rd_data_q <= rd_data_d;
      region_q  <= region_d;
    end
  end

  assign busy_o         = (state_q == CLEAR);
  assign rd_data_o      = rd_data_q;
  assign csr_pmp_addr_o = region_q;
  assign lock_o         = lock_q;

endmodule

// File: tb/tb_pmp_addr_bank.sv
module tb_pmp_addr_bank;

  localparam logic [33:0] ONES = 34'h3_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Default instance (4 regions)
  logic        wr_req, wr_lock, clr, wr_ready, wr_err, busy;
  logic [1:0]  wr_idx, rd_idx;
  logic [33:0] wr_data, rd_data;
  logic [33:0] csr [4];
  logic [3:0]  lock;

  // 5-region instance, exercises out-of-range indices
  logic        wr_req5, wr_lock5, clr5, wr_ready5, wr_err5, busy5;
  logic [2:0]  wr_idx5, rd_idx5;
  logic [33:0] wr_data5, rd_data5;
  logic [33:0] csr5 [5];
  logic [4:0]  lock5;

  pmp_addr_bank dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wr_req_i(wr_req), .wr_idx_i(wr_idx), .wr_data_i(wr_data), .wr_lock_i(wr_lock),
    .wr_ready_o(wr_ready), .wr_err_o(wr_err),
    .clr_req_i(clr), .busy_o(busy),
    .rd_idx_i(rd_idx), .rd_data_o(rd_data),
    .csr_pmp_addr_o(csr), .lock_o(lock)
  );

  pmp_addr_bank #(.PMPNumRegions(5)) dut5 (
    .clk_i(clk), .rst_ni(rst_n),
    .wr_req_i(wr_req5), .wr_idx_i(wr_idx5), .wr_data_i(wr_data5), .wr_lock_i(wr_lock5),
    .wr_ready_o(wr_ready5), .wr_err_o(wr_err5),
    .clr_req_i(clr5), .busy_o(busy5),
    .rd_idx_i(rd_idx5), .rd_data_o(rd_data5),
    .csr_pmp_addr_o(csr5), .lock_o(lock5)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        wr_req;
    logic [1:0]  idx;
    logic [33:0] data;
    logic        lk;
    logic        clr;
    logic [1:0]  rd_idx;
    logic        c_ready;
    logic        c_err;
    logic        c_busy;
    logic [33:0] p_rd;
    logic [3:0]  p_lock;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mk(logic r, logic [1:0] i, logic [33:0] d, logic l, logic c,
                              logic [1:0] ri, logic er, logic ee, logic eb,
                              logic [33:0] prd, logic [3:0] pl);
    vec_t v;
    v.wr_req = r; v.idx = i; v.data = d; v.lk = l; v.clr = c; v.rd_idx = ri;
    v.c_ready = er; v.c_err = ee; v.c_busy = eb; v.p_rd = prd; v.p_lock = pl;
    return v;
  endfunction

  // Reference model: region contents, lock bits and the list of regions the
  // running clear still has to visit.
  logic [33:0] regs_m [4];
  logic [3:0]  lock_m;
  int          clr_q [$];

  task automatic model_reset();
    for (int k = 0; k < 4; k++) regs_m[k] = ONES;
    lock_m = '0;
    clr_q.delete();
  endtask

  task automatic idle_inputs();
    wr_req = 0; wr_idx = 0; wr_data = 0; wr_lock = 0; clr = 0; rd_idx = 0;
    wr_req5 = 0; wr_idx5 = 0; wr_data5 = 0; wr_lock5 = 0; clr5 = 0; rd_idx5 = 0;
  endtask

  // Called at posedge+1; returns at posedge+1.
  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    model_reset();
    #2;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic do_write(input logic [1:0] i, input logic [33:0] d, input logic l,
                          input logic exp_err, input string name);
    wr_req = 1; wr_idx = i; wr_data = d; wr_lock = l;
    @(negedge clk);
    chk({name, "_err"}, wr_err, exp_err);
    @(posedge clk); #1;
    wr_req = 0; wr_lock = 0;
  endtask

  initial begin
    int stall, nbusy, got;
    logic [63:0] tmp;
    logic        exp_ready, exp_err, exp_busy, acc;
    logic [33:0] exp_rd;

    vecs[0]  = mk(0, 0, 34'h0,    0, 0, 0, 1, 0, 0, ONES,     4'b0000);
    vecs[1]  = mk(1, 1, 34'h1234, 1, 0, 1, 1, 0, 0, ONES,     4'b0010);
    vecs[2]  = mk(1, 1, 34'h5,    0, 0, 1, 1, 1, 0, 34'h1234, 4'b0010);
    vecs[3]  = mk(0, 0, 34'h0,    0, 0, 1, 1, 0, 0, 34'h1234, 4'b0010);
    vecs[4]  = mk(1, 0, 34'h1,    0, 0, 0, 1, 0, 0, ONES,     4'b0010);
    vecs[5]  = mk(1, 2, 34'h3,    1, 0, 0, 1, 0, 0, 34'h1,    4'b0110);
    vecs[6]  = mk(1, 3, 34'h4,    0, 0, 2, 1, 0, 0, 34'h3,    4'b0110);
    vecs[7]  = mk(0, 0, 34'h0,    0, 1, 3, 0, 0, 0, 34'h4,    4'b0110);
    vecs[8]  = mk(0, 0, 34'h0,    0, 0, 0, 0, 0, 1, 34'h1,    4'b0110);
    vecs[9]  = mk(1, 0, 34'h77,   1, 0, 0, 0, 0, 1, ONES,     4'b0110);
    vecs[10] = mk(0, 0, 34'h0,    0, 1, 1, 0, 0, 1, 34'h1234, 4'b0110);
    vecs[11] = mk(0, 0, 34'h0,    0, 0, 3, 0, 0, 1, 34'h4,    4'b0110);
    vecs[12] = mk(0, 0, 34'h0,    0, 0, 3, 1, 0, 0, ONES,     4'b0110);
    vecs[13] = mk(0, 0, 34'h0,    0, 0, 2, 1, 0, 0, 34'h3,    4'b0110);
    vecs[14] = mk(0, 0, 34'h0,    0, 0, 0, 1, 0, 0, ONES,     4'b0110);

    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;

    // Reset values
    @(negedge clk);
    for (int k = 0; k < 4; k++) chk($sformatf("rst_region%0d", k), csr[k], ONES);
    chk("rst_lock", lock, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", wr_ready, 1'b1);
    chk("rst_rd", rd_data, 34'h0);
    @(posedge clk); #1;

    // Table-driven vectors
    for (int i = 0; i < 15; i++) begin
      wr_req = vecs[i].wr_req; wr_idx = vecs[i].idx; wr_data = vecs[i].data;
      wr_lock = vecs[i].lk; clr = vecs[i].clr; rd_idx = vecs[i].rd_idx;
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), wr_ready, vecs[i].c_ready);
      chk($sformatf("vec%0d_err", i),   wr_err,   vecs[i].c_err);
      chk($sformatf("vec%0d_busy", i),  busy,     vecs[i].c_busy);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_rd", i),    rd_data,  vecs[i].p_rd);
      chk($sformatf("vec%0d_lock", i),  lock,     vecs[i].p_lock);
    end
    idle_inputs();

    // Clear walk with region 2 locked
    do_reset();
    do_write(0, 34'h1, 0, 0, "w0");
    do_write(1, 34'h2, 0, 0, "w1");
    do_write(2, 34'h3, 1, 0, "w2");
    do_write(3, 34'h4, 0, 0, "w3");
    clr = 1;
    @(posedge clk); #1;
    clr = 0;
    nbusy = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (busy) nbusy++;
    end
    chk("clr_busy_cycles", nbusy, 4);
    chk("clr_region0", csr[0], ONES);
    chk("clr_region1", csr[1], ONES);
    chk("clr_region2", csr[2], 34'h3);
    chk("clr_region3", csr[3], ONES);
    chk("clr_lock", lock, 4'b0100);
    @(posedge clk); #1;

    // Clear and write in the same cycle: the write stalls behind the clear
    clr = 1; wr_req = 1; wr_idx = 0; wr_data = 34'hABC; wr_lock = 0;
    stall = 0; got = 0;
    for (int k = 0; k < 20 && got == 0; k++) begin
      @(negedge clk);
      if (wr_ready) begin
        got = 1;
        chk("clrwr_err", wr_err, 1'b0);
      end else begin
        stall++;
      end
      @(posedge clk); #1;
      clr = 0;
    end
    wr_req = 0;
    chk("clrwr_accepted", got, 1);
    chk("clrwr_stall", stall, 5);
    chk("clrwr_region0", csr[0], 34'hABC);
    chk("clrwr_busy", busy, 1'b0);

    // Reset in the middle of a clear walk
    do_reset();
    do_write(0, 34'h9, 1, 0, "abort_w0");
    clr = 1;
    @(posedge clk); #1;
    clr = 0;
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_lock", lock, 4'b0000);
    for (int k = 0; k < 4; k++) chk($sformatf("abort_region%0d", k), csr[k], ONES);
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("abort_ready", wr_ready, 1'b1);
    chk("abort_busy_after", busy, 1'b0);
    @(posedge clk); #1;

    // Out-of-range indices on the 5-region instance
    wr_req5 = 1; wr_idx5 = 6; wr_data5 = 34'h55; wr_lock5 = 1; rd_idx5 = 7;
    @(negedge clk);
    chk("oob_ready", wr_ready5, 1'b1);
    chk("oob_err", wr_err5, 1'b1);
    @(posedge clk); #1;
    chk("oob_rd", rd_data5, 34'h0);
    chk("oob_lock", lock5, 5'b00000);
    for (int k = 0; k < 5; k++) chk($sformatf("oob_region%0d", k), csr5[k], ONES);
    wr_idx5 = 4; wr_data5 = 34'h44; wr_lock5 = 0; rd_idx5 = 4;
    @(negedge clk);
    chk("last_err", wr_err5, 1'b0);
    @(posedge clk); #1;
    chk("last_rd_before", rd_data5, ONES);
    chk("last_region4", csr5[4], 34'h44);
    wr_req5 = 0;
    @(posedge clk); #1;
    chk("last_rd_after", rd_data5, 34'h44);
    rd_idx5 = 0;

    // Random traffic against the reference model
    for (int b = 0; b < 3; b++) begin
      do_reset();
      for (int i = 0; i < 100; i++) begin
        wr_req  = ($urandom_range(0, 9) < 6);
        wr_idx  = 2'($urandom_range(0, 3));
        tmp     = {$urandom(), $urandom()};
        wr_data = tmp[33:0];
        wr_lock = ($urandom_range(0, 9) == 0);
        clr     = ($urandom_range(0, 11) == 0);
        rd_idx  = 2'($urandom_range(0, 3));

        exp_busy  = (clr_q.size() != 0);
        exp_ready = !exp_busy && !clr;
        acc       = wr_req && exp_ready;
        exp_err   = acc && lock_m[wr_idx];
        exp_rd    = regs_m[rd_idx];

        @(negedge clk);
        chk($sformatf("rnd%0d_%0d_ready", b, i), wr_ready, exp_ready);
        chk($sformatf("rnd%0d_%0d_err", b, i),   wr_err,   exp_err);
        chk($sformatf("rnd%0d_%0d_busy", b, i),  busy,     exp_busy);

        if (acc && !exp_err) begin
          regs_m[wr_idx] = wr_data;
          if (wr_lock) lock_m[wr_idx] = 1'b1;
        end
        if (clr_q.size() != 0) begin
          int r;
          r = clr_q.pop_front();
          if (!lock_m[r]) regs_m[r] = ONES;
        end else if (clr) begin
          for (int k = 0; k < 4; k++) clr_q.push_back(k);
        end

        @(posedge clk); #1;
        chk($sformatf("rnd%0d_%0d_rd", b, i),   rd_data, exp_rd);
        chk($sformatf("rnd%0d_%0d_lock", b, i), lock,    lock_m);
        for (int k = 0; k < 4; k++)
          chk($sformatf("rnd%0d_%0d_region%0d", b, i, k), csr[k], regs_m[k]);
      end
      idle_inputs();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pmp_addr_bank.md
PMP_ADDR_BANK -- requirements
Module: pmp_addr_bank

Interface
REQ-001 The block SHALL have parameter PMPNumRegions, default 4, meaning the number of address regions (legal range 1..64).
REQ-002 The block SHALL have parameter PMPAddrWidth, default 34, meaning the width of each region address.
REQ-003 The block SHALL have parameter ClearValue, default all-ones of PMPAddrWidth, meaning the value loaded by reset and by the clear sequence.
REQ-004 The block SHALL derive IdxW = max(1, clog2(PMPNumRegions)) for all index ports.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset; the port list SHALL be:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- wr_req_i  input  1  write request; held until accepted
- wr_idx_i  input  IdxW  target region
- wr_data_i  input  PMPAddrWidth  write data
- wr_lock_i  input  1  lock the region together with this write
- wr_ready_o  output  1  write can be accepted this cycle
- wr_err_o  output  1  accepted write was rejected
- clr_req_i  input  1  single-cycle pulse starting the clear sequence
- busy_o  output  1  clear sequence in progress
- rd_idx_i  input  IdxW  read region
- rd_data_o  output  PMPAddrWidth  registered read data
- csr_pmp_addr_o  output  PMPAddrWidth x PMPNumRegions (unpacked)  all region addresses
- lock_o  output  PMPNumRegions (packed)  per-region lock bits

Function
REQ-010 The block SHALL implement a two-state FSM, IDLE and CLEAR.
REQ-011 wr_ready_o SHALL equal (state==IDLE) and not clr_req_i; clear takes priority over a simultaneous write, and the write stalls.
REQ-012 A write SHALL be accepted in any cycle with wr_req_i and wr_ready_o both high; both wr_ready_o and wr_err_o are combinational in that cycle.
REQ-013 An accepted write SHALL be rejected (wr_err_o=1, no state change) when lock_o[wr_idx_i]=1 or when wr_idx_i >= PMPNumRegions.
REQ-014 A non-rejected accepted write SHALL update csr_pmp_addr_o[wr_idx_i] to wr_data_i at the next clock edge, and set lock_o[wr_idx_i] when wr_lock_i=1.
REQ-015 wr_err_o SHALL be 0 in every cycle without an accepted write.
REQ-016 Lock bits SHALL only be set by writes and only be cleared by reset; the clear sequence SHALL NOT alter them.
REQ-017 In IDLE, clr_req_i=1 SHALL move the FSM to CLEAR with the region counter at 0.
REQ-018 In CLEAR, each cycle SHALL load ClearValue into region[counter] if that region is unlocked, leave it unchanged if locked, and then increment the counter.
REQ-019 After region PMPNumRegions-1 is processed, the FSM SHALL return to IDLE; busy_o SHALL be high for exactly PMPNumRegions cycles.
REQ-020 clr_req_i SHALL be ignored while in CLEAR.
REQ-021 rd_data_o SHALL present region[rd_idx_i] one cycle after rd_idx_i is sampled, reflecting register contents before that edge's update.
REQ-022 rd_data_o SHALL be 0 for rd_idx_i >= PMPNumRegions.
REQ-023 Reads SHALL operate identically in IDLE and CLEAR.
REQ-024 csr_pmp_addr_o and lock_o SHALL be direct register outputs with zero latency.

Reset
REQ-030 rst_ni low SHALL asynchronously set: all regions to ClearValue, lock_o to 0, FSM to IDLE, counter to 0, busy_o to 0, rd_data_o to 0.
REQ-031 Reset asserted mid-CLEAR SHALL abort the sequence; after release, the FSM SHALL be in IDLE with wr_ready_o=1.

Verification
REQ-040 Reset release with defaults -> csr_pmp_addr_o[0..3]=34'h3_FFFF_FFFF, lock_o=4'b0000, busy_o=0, wr_ready_o=1.
REQ-041 Write idx 1, data 34'h0_0000_1234, lock=1; then write idx 1, data 34'h5 -> first write wr_err_o=0, region1=34'h1234, lock_o=4'b0010; second write wr_err_o=1, region1 unchanged.
REQ-042 Regions 0..3 written with 1,2,3,4, region 2 locked, then clr_req_i pulse -> busy_o high for 4 cycles; regions 0,1,3 = all-ones, region 2 = 3.
REQ-043 clr_req_i and wr_req_i high in the same IDLE cycle -> wr_ready_o=0 for 5 cycles (that cycle plus 4 CLEAR cycles); the held write is accepted on the first IDLE cycle and lands after the clear.
REQ-044 PMPNumRegions=5: write idx 6 -> wr_err_o=1, no state change; rd_idx_i=7 -> rd_data_o=0 next cycle.
REQ-045 rst_ni asserted during CLEAR cycle 2 with region 0 locked -> immediately busy_o=0, lock_o=0, all regions all-ones.
